// File: rtl/key_schedule_ctrl3_simon_pkg.sv
// Shared types and constants for the 3-share bit-serial Simon key-schedule controller.
// Holds the FSM state enum, the datapath mux select encodings and the Z2 round-constant sequence.
package simon3_ks_pkg;

   localparam int WORD_BITS = 64;
   localparam int ROUNDS    = 68;
   localparam int LOAD_BITS = 128;
   localparam int LUT_BITS  = 4;
   localparam int Z_LEN     = 62;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      S1_FIFO  = 2'd0,
      S1_DIN   = 2'd1,
      S1_LUT   = 2'd2,
      S1_LUTFF = 2'd3
   } s1_sel_t;

   typedef enum logic [1:0] {
      S3_LOAD  = 2'd1,
      S3_FIFO  = 2'd2,
      S3_LUTFF = 2'd3
   } s3_sel_t;

   // Ascending range so Z2[0] is the first element of the published sequence.
   localparam logic [0:Z_LEN-1] Z2 =
      62'b10101111011100000011010010011000101000010001111110010110110011;

   function automatic logic z2Bit(input logic [5:0] idx);
      return (idx < 6'(Z_LEN)) ? Z2[idx] : 1'b0;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl3_simon_counter.sv
// Bit/round counter pair for the Simon key-schedule controller.
// Bit index wraps at WORD_BITS and carries into the round index; clear beats enable.
module simon_bit_round_counter #(
   parameter int WORD_BITS = 64,
   parameter int ROUNDS    = 68,
   parameter int BIT_W     = 6,
   parameter int ROUND_W   = 7
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_enable,
   output logic [BIT_W-1:0]   o_bit,
   output logic [ROUND_W-1:0] o_round,
   output logic               o_bitLast,
   output logic               o_roundLast,
   output logic               o_roundStep
);

   logic [BIT_W-1:0]   r_bit;
   logic [ROUND_W-1:0] r_round;
   logic               w_bitLast;
   logic               w_roundLast;

   assign w_bitLast   = (r_bit == BIT_W'(WORD_BITS - 1));
   assign w_roundLast = (r_round == ROUND_W'(ROUNDS - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bit   <= '0;
         r_round <= '0;
      end else if (i_clear) begin
         r_bit   <= '0;
         r_round <= '0;
      end else if (i_enable) begin
         if (w_bitLast) begin
            r_bit   <= '0;
            r_round <= w_roundLast ? '0 : r_round + 1'b1;
         end else begin
            r_bit <= r_bit + 1'b1;
         end
      end
   end

   assign o_bit       = r_bit;
   assign o_round     = r_round;
   assign o_bitLast   = w_bitLast;
   assign o_roundLast = w_roundLast;
   assign o_roundStep = i_enable && !i_clear && w_bitLast;

endmodule

// File: rtl/key_schedule_ctrl3_simon.sv
// Control FSM for one share of the bit-serial 3-share Simon key schedule (IDLE -> LOAD -> RUN).
// Optional macro SIMON_ZCONST_EN adds o_key_const, the per-bit round-constant injection decode.
module key_schedule_ctrl3_simon
   import simon3_ks_pkg::*;
#(
   parameter int WORD_BITS = simon3_ks_pkg::WORD_BITS,
   parameter int ROUNDS    = simon3_ks_pkg::ROUNDS,
   parameter int LOAD_BITS = simon3_ks_pkg::LOAD_BITS,
   parameter int LUT_BITS  = simon3_ks_pkg::LUT_BITS
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_stall,
   output logic [1:0] o_s1,
   output logic       o_s2,
   output logic [1:0] o_s3,
   output logic       o_shifter_enable1,
   output logic       o_shifter_enable2,
   output logic       o_fifo_ff_enable,
   output logic       o_lut_ff_enable,
   output logic [5:0] o_bit_counter,
   output logic [6:0] o_round_counter,
   output logic       o_round_counter_out,
   output logic       o_key_valid,
   output logic       o_done
`ifdef SIMON_ZCONST_EN
   ,output logic      o_key_const
`endif
);

   state_t     r_state;
   state_t     w_stateNext;
   logic       r_done;
   logic       w_doneNext;
   logic       w_cntClear;
   logic       w_cntEnable;
   logic [5:0] w_bit;
   logic [6:0] w_round;
   logic       w_bitLast;
   logic       w_roundLast;
   logic       w_roundStep;
   logic       w_loadLast;
   logic       w_runLast;
   logic       w_firstRound;
   logic       w_lutPhase;

   simon_bit_round_counter #(
      .WORD_BITS (WORD_BITS),
      .ROUNDS    (ROUNDS),
      .BIT_W     (6),
      .ROUND_W   (7)
   ) u_counter (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_cntClear),
      .i_enable    (w_cntEnable),
      .o_bit       (w_bit),
      .o_round     (w_round),
      .o_bitLast   (w_bitLast),
      .o_roundLast (w_roundLast),
      .o_roundStep (w_roundStep)
   );

   // During LOAD the low round bit extends the bit counter into a 0..127 load index.
   assign w_loadLast   = ({w_round[0], w_bit} == 7'(LOAD_BITS - 1));
   assign w_runLast    = w_bitLast && w_roundLast;
   assign w_firstRound = (w_round == 7'd0);
   assign w_lutPhase   = (w_bit < 6'(LUT_BITS));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_done  <= w_doneNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_doneNext  = 1'b0;
      w_cntClear  = 1'b0;
      w_cntEnable = 1'b0;
      if (!i_stall) begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_stateNext = ST_LOAD;
                  w_cntClear  = 1'b1;
               end
            end
            ST_LOAD: begin
               if (w_loadLast) begin
                  w_stateNext = ST_RUN;
                  w_cntClear  = 1'b1;
               end else begin
                  w_cntEnable = 1'b1;
               end
            end
            ST_RUN: begin
               if (w_runLast) begin
                  w_stateNext = ST_IDLE;
                  w_cntClear  = 1'b1;
                  w_doneNext  = 1'b1;
               end else begin
                  w_cntEnable = 1'b1;
               end
            end
            default: w_stateNext = ST_IDLE;
         endcase
      end
   end

   // Selects always follow state/counters; every enable (and key_valid, since the
   // datapath does not advance) is suppressed while the datapath is stalled.
   always_comb begin
      o_s1              = S1_FIFO;
      o_s2              = 1'b0;
      o_s3              = S3_LOAD;
      o_shifter_enable1 = 1'b0;
      o_shifter_enable2 = 1'b0;
      o_fifo_ff_enable  = 1'b0;
      o_lut_ff_enable   = 1'b0;
      o_key_valid       = 1'b0;
      case (r_state)
         ST_LOAD: begin
            o_s1              = S1_DIN;
            o_s3              = S3_LOAD;
            o_shifter_enable1 = !i_stall;
            o_shifter_enable2 = !i_stall;
            o_fifo_ff_enable  = !i_stall;
         end
         ST_RUN: begin
            o_key_valid       = !i_stall;
            o_shifter_enable1 = !i_stall;
            o_shifter_enable2 = !i_stall;
            o_fifo_ff_enable  = !i_stall && w_firstRound;
            o_lut_ff_enable   = !i_stall && w_lutPhase;
            o_s2              = !w_firstRound;
            if (w_lutPhase) begin
               o_s1 = w_firstRound ? S1_FIFO : S1_LUTFF;
               o_s3 = w_firstRound ? S3_FIFO : S3_LUTFF;
            end else begin
               o_s1 = S1_LUT;
               o_s3 = S3_FIFO;
            end
         end
         default: begin
            o_s1 = S1_FIFO;
            o_s3 = S3_LOAD;
         end
      endcase
   end

   assign o_bit_counter       = w_bit;
   assign o_round_counter     = w_round;
   assign o_round_counter_out = w_round[0];
   assign o_done              = r_done;

`ifdef SIMON_ZCONST_EN
   logic [5:0] r_zIdx;

   // Tracks round % 62 so Z2 can be indexed without a divider.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_cntClear) begin
         r_zIdx <= '0;
      end else if (w_roundStep && (r_state == ST_RUN)) begin
         r_zIdx <= (r_zIdx == 6'(Z_LEN - 1)) ? 6'd0 : r_zIdx + 1'b1;
      end
   end

   always_comb begin
      o_key_const = 1'b0;
      if (r_state == ST_RUN) begin
         if (w_bit == 6'd0) begin
            o_key_const = z2Bit(r_zIdx);
         end else if (w_bit == 6'd1) begin
            o_key_const = 1'b0;
         end else begin
            o_key_const = 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_key_schedule_ctrl3_simon.sv
// Self-checking bench for key_schedule_ctrl3_simon: linear-index reference model plus directed checks.
module tb_key_schedule_ctrl3_simon;

   localparam int WB      = 64;
   localparam int NR      = 68;
   localparam int LB      = 128;
   localparam int RUN_LEN = WB * NR;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stall;
   logic [1:0] s1;
   logic       s2;
   logic [1:0] s3;
   logic       sh1;
   logic       sh2;
   logic       fifoEn;
   logic       lutEn;
   logic [5:0] bitCnt;
   logic [6:0] roundCnt;
   logic       roundOut;
   logic       keyValid;
   logic       done;
`ifdef SIMON_ZCONST_EN
   logic       keyConst;
   logic [0:61] tbZ2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
`endif

   int checks   = 0;
   int failures = 0;
   int tickCount = 0;

   key_schedule_ctrl3_simon dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_start             (start),
      .i_stall             (stall),
      .o_s1                (s1),
      .o_s2                (s2),
      .o_s3                (s3),
      .o_shifter_enable1   (sh1),
      .o_shifter_enable2   (sh2),
      .o_fifo_ff_enable    (fifoEn),
      .o_lut_ff_enable     (lutEn),
      .o_bit_counter       (bitCnt),
      .o_round_counter     (roundCnt),
      .o_round_counter_out (roundOut),
      .o_key_valid         (keyValid),
      .o_done              (done)
`ifdef SIMON_ZCONST_EN
      ,.o_key_const        (keyConst)
`endif
   );

   always #5 clk = ~clk;

   // Reference: phase 0 idle, 1 load, 2 run; idx is the linear cycle index within the phase.
   int mPhase = 0;
   int mIdx   = 0;
   bit mDone  = 0;
   bit mValid = 0;

   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0; mIdx = 0; mDone = 0;
      end else if (stall) begin
         mDone = 0;
      end else begin
         mDone = 0;
         case (mPhase)
            0: if (start) begin mPhase = 1; mIdx = 0; end
            1: if (mIdx == LB - 1) begin mPhase = 2; mIdx = 0; end else mIdx++;
            default: if (mIdx == RUN_LEN - 1) begin mPhase = 0; mIdx = 0; mDone = 1; end else mIdx++;
         endcase
      end
      mValid = 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mValid) begin
         int eBit, eRound, eS1, eS3;
         bit load, run;
         load   = (mPhase == 1);
         run    = (mPhase == 2);
         eBit   = (load || run) ? mIdx % WB : 0;
         eRound = (load || run) ? mIdx / WB : 0;
         eS1    = load ? 1 : run ? ((eBit < 4) ? ((eRound == 0) ? 0 : 3) : 2) : 0;
         eS3    = run ? ((eBit < 4) ? ((eRound == 0) ? 2 : 3) : 2) : 1;
         checkOutput("m_bit",      bitCnt,   eBit);
         checkOutput("m_round",    roundCnt, eRound);
         checkOutput("m_parity",   roundOut, eRound % 2);
         checkOutput("m_s1",       s1,       eS1);
         checkOutput("m_s2",       s2,       (run && eRound != 0) ? 1 : 0);
         checkOutput("m_s3",       s3,       eS3);
         checkOutput("m_sh1",      sh1,      ((load || run) && !stall) ? 1 : 0);
         checkOutput("m_sh2",      sh2,      ((load || run) && !stall) ? 1 : 0);
         checkOutput("m_fifoEn",   fifoEn,   (!stall && (load || (run && eRound == 0))) ? 1 : 0);
         checkOutput("m_lutEn",    lutEn,    (!stall && run && eBit < 4) ? 1 : 0);
         checkOutput("m_keyValid", keyValid, (run && !stall) ? 1 : 0);
         checkOutput("m_done",     done,     mDone ? 1 : 0);
`ifdef SIMON_ZCONST_EN
         checkOutput("m_keyConst", keyConst,
                     run ? ((eBit == 0) ? tbZ2[eRound % 62] : (eBit == 1) ? 0 : 1) : 0);
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      tickCount++;
   endtask

   task automatic applyStimulus(input logic r, input logic st, input logic sl);
      rst = r; start = st; stall = sl;
   endtask

   task automatic waitFor(input int r, input int b, input int bound, input string name);
      int n = 0;
      while (!(roundCnt == 7'(r) && bitCnt == 6'(b)) && n < bound) begin
         tick();
         n++;
      end
      checkOutput(name, (roundCnt == 7'(r) && bitCnt == 6'(b)) ? 1 : 0, 1);
   endtask

   task automatic waitDone(input int bound, output int taken);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      taken = n;
      checkOutput("done_seen", done, 1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int mark;
      int taken;
      applyStimulus(1, 0, 0);
      repeat (3) tick();
      applyStimulus(0, 0, 0);
      repeat (5) tick();
      checkOutput("idle_s3",       s3, 1);
      checkOutput("idle_s1",       s1, 0);
      checkOutput("idle_keyValid", keyValid, 0);
      checkOutput("idle_bit",      bitCnt, 0);
      checkOutput("idle_round",    roundCnt, 0);
      checkOutput("idle_done",     done, 0);
      checkOutput("idle_sh1",      sh1, 0);
      checkOutput("idle_fifoEn",   fifoEn, 0);

      // Run A: clean key schedule, latency and total length.
      mark = tickCount;
      applyStimulus(0, 1, 0);
      n = 0;
      do begin
         tick();
         n++;
         start = 0;
         if (n == 1) checkOutput("load_s1", s1, 1);
      end while (keyValid !== 1'b1 && n < 200);
      checkOutput("latency", n, 129);
      checkOutput("r0b0_bit",    bitCnt, 0);
      checkOutput("r0b0_round",  roundCnt, 0);
      checkOutput("r0b0_s1",     s1, 0);
      checkOutput("r0b0_s3",     s3, 2);
      checkOutput("r0b0_fifoEn", fifoEn, 1);
      checkOutput("r0b0_lutEn",  lutEn, 1);
`ifdef SIMON_ZCONST_EN
      checkOutput("z_r0b0", keyConst, 1);
      tick();
      checkOutput("z_r0b1", keyConst, 0);
      tick();
      checkOutput("z_r0b2", keyConst, 1);
`endif
      waitFor(1, 0, 200, "reach_r1b0");
      checkOutput("r1b0_s1",    s1, 3);
      checkOutput("r1b0_s3",    s3, 3);
      checkOutput("r1b0_s2",    s2, 1);
      checkOutput("r1b0_lutEn", lutEn, 1);
      checkOutput("r1b0_fifo",  fifoEn, 0);
      repeat (4) tick();
      checkOutput("r1b4_s1",    s1, 2);
      checkOutput("r1b4_s3",    s3, 2);
      checkOutput("r1b4_lutEn", lutEn, 0);
`ifdef SIMON_ZCONST_EN
      waitFor(62, 0, 4000, "reach_r62b0");
      checkOutput("z_r62b0", keyConst, 1);
`endif
      waitDone(5000, taken);
      checkOutput("start_to_done", tickCount - mark, 1 + LB + RUN_LEN);
      tick();
      checkOutput("done_pulse_len", done, 0);

      // Run B: stall at round 5 bit 2, then reset mid-RUN.
      applyStimulus(0, 1, 0);
      tick();
      start = 0;
      waitFor(5, 2, 1000, "reach_r5b2");
      stall = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("stall_bit",      bitCnt, 2);
         checkOutput("stall_round",    roundCnt, 5);
         checkOutput("stall_sh1",      sh1, 0);
         checkOutput("stall_keyValid", keyValid, 0);
      end
      stall = 0;
      #1;
      checkOutput("resume_bit", bitCnt, 2);
      checkOutput("resume_sh1", sh1, 1);
      tick();
      checkOutput("resume_next_bit", bitCnt, 3);
      waitFor(30, 40, 3000, "reach_r30b40");
      rst = 1;
      tick();
      checkOutput("rst_bit",      bitCnt, 0);
      checkOutput("rst_round",    roundCnt, 0);
      checkOutput("rst_keyValid", keyValid, 0);
      checkOutput("rst_done",     done, 0);
      checkOutput("rst_s3",       s3, 1);
      rst = 0;
      repeat (5) tick();

      // Run C: restart after the aborted run must complete normally.
      applyStimulus(0, 1, 0);
      tick();
      start = 0;
      waitDone(5000, taken);
      checkOutput("rerun_len", taken + 1, 1 + LB + RUN_LEN);
      tick();
      checkOutput("rerun_done_len", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
